sseg_scroll_banner: RTL
=======================

SSEG_SCROLL_BANNER -- requirements
Module: sseg_scroll_banner

Interface
REQ-001 Parameter MSG_LEN, default 10: message length in hex nibbles; legal range is DIGITS+1 to 64.
REQ-002 Parameter DIGITS, default 4: number of multiplexed seven-segment digits; legal range is 1 to 8.
REQ-003 Parameter STEP_DIV, default 50000000: clk cycles per scroll step; minimum 2.
REQ-004 Parameter REFRESH_BITS, default 16: each digit is lit for 2^REFRESH_BITS clk cycles.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  1 = scrolling enabled; 0 = hold position.
REQ-008 dir  in  1  wrap mode only: 0 = pos increments, 1 = pos decrements.
REQ-009 mode  in  1  0 = wrap (circular), 1 = bounce (ping-pong).
REQ-010 load  in  1  single-cycle strobe that captures data.
REQ-011 data  in  MSG_LEN*4  message; nibble i is data[4i+3:4i].
REQ-012 an  out  DIGITS  active-low anode enables; an[DIGITS-1] is the leftmost digit.
REQ-013 sseg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 pos  out  clog2(MSG_LEN)  current window start index.

Function
REQ-015 On load, the block SHALL copy data into an internal message register msg, set pos=0, set bounce state FWD and clear the step counter.
REQ-016 The step counter SHALL count 0..STEP_DIV-1 continuously, and step_tick SHALL be asserted internally when the count equals STEP_DIV-1.
REQ-017 pos SHALL change only on a step_tick cycle with en=1 and load=0; load SHALL take priority over a simultaneous tick.
REQ-018 In wrap mode, pos SHALL become (pos+1) mod MSG_LEN when dir=0 and (pos-1) mod MSG_LEN when dir=1; pos=0 decrements to MSG_LEN-1.
REQ-019 Bounce mode SHALL use a two-state FSM (FWD, REV) and SHALL ignore dir; let PMAX = MSG_LEN-DIGITS.
REQ-020 Bounce FWD: if pos<PMAX, pos increments; if pos>=PMAX, pos becomes PMAX-1 and the state becomes REV.
REQ-021 Bounce REV: if pos>0, pos decrements (clamped to PMAX-1 if pos>PMAX); if pos=0, pos becomes 1 and the state becomes FWD.
REQ-022 A mode change SHALL take effect on the next step tick and SHALL NOT reset pos.
REQ-023 A digit-select counter SHALL advance every 2^REFRESH_BITS cycles, cycling DIGITS-1 down to 0 and then wrapping.
REQ-024 With select value k, the display position SHALL be j = DIGITS-1-k, where j=0 is the leftmost digit.
REQ-025 For display position j, the block SHALL show nibble msg[(pos+j) mod MSG_LEN] on sseg, and only an[k] SHALL be low.
REQ-026 an and sseg SHALL be registered, giving one clk of latency from a select or pos change to the output.
REQ-027 The hex decode SHALL use the following active-low patterns:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
REQ-028 Modulo index arithmetic SHALL NOT use a divider; a compare-and-subtract against MSG_LEN is sufficient because pos+j < 2*MSG_LEN.

Reset
REQ-029 While reset is high, the block SHALL hold msg=0, pos=0, state FWD, step counter 0, refresh counter 0 and digit select DIGITS-1.
REQ-030 While reset is high, outputs SHALL be an = all ones (blank) and sseg = 1111111.
REQ-031 On reset assertion mid-operation, all state SHALL clear immediately, independent of clk.
REQ-032 After reset deassertion, display SHALL resume from the reset state on the next rising edge of clk.

Structure
REQ-033 A package sseg_pkg SHALL hold the 16-entry segment table, the SEG_BLANK constant (1111111) and the bounce-state enumeration.
REQ-034 Hex decoding SHALL be implemented in a single sub-module, sseg_hex_decoder (4-bit in, 7-bit out, combinational).
REQ-035 All other logic (counters, FSM, window indexing) SHALL reside in sseg_scroll_banner.

Verification
All scenarios SHALL use MSG_LEN=6, DIGITS=4, STEP_DIV=4, REFRESH_BITS=1.
REQ-036 Reset test: assert reset mid-scroll -> an=1111 and sseg=1111111 immediately; pos=0.
REQ-037 Display test: load data=0x543210 with en=0 -> the left-to-right scan shows 0,1,2,3; an cycles 0111, 1011, 1101, 1110, each lit for 2 clks.
REQ-038 Wrap test: en=1, dir=0 -> pos steps 0,1,2,3,4,5,0 every 4 clks; at pos=5 the display shows 5,0,1,2. With dir=1 from pos=0, the next pos SHALL be 5.
REQ-039 Bounce test: mode=1 -> pos sequence 0,1,2,1,0,1,2.
REQ-040 Mode-switch test: switch to mode=1 while pos=4 -> next tick sets pos=1 and state REV.
REQ-041 Priority test: pulse load on the same cycle as step_tick -> pos=0 and msg updated; no step is taken.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the scrolling seven-segment banner: segment patterns,
// blank pattern and the bounce direction states.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic {
        BNC_FWD,
        BNC_REV
    } bounce_state_t;

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/sseg_scroll_banner.sv
// Scrolls a hex message across a multiplexed seven-segment display, in
// circular (wrap) or ping-pong (bounce) fashion.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   BNC_FWD | bounce mode, window moving right (pos increasing)
//   BNC_REV | bounce mode, window moving left (pos decreasing)
module sseg_scroll_banner
    import sseg_pkg::*;
#(
    parameter int MSG_LEN      = 10,
    parameter int DIGITS       = 4,
    parameter int STEP_DIV     = 50000000,
    parameter int REFRESH_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       mode,
    input  logic                       load,
    input  logic [MSG_LEN*4-1:0]       data,
    output logic [DIGITS-1:0]          an,
    output logic [6:0]                 sseg,
    output logic [$clog2(MSG_LEN)-1:0] pos
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(STEP_DIV);

    localparam logic [PW-1:0] POS_LAST  = PW'(MSG_LEN - 1);
    localparam logic [PW-1:0] PMAX      = PW'(MSG_LEN - DIGITS);
    localparam logic [PW-1:0] MSG_LEN_T = PW'(MSG_LEN);
    localparam logic [PW:0]   MSG_LEN_X = (PW+1)'(MSG_LEN);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);
    localparam logic [SW-1:0] SEL_FIRST = SW'(DIGITS - 1);

    logic [MSG_LEN-1:0][3:0]  msg;
    bounce_state_t            state;
    logic [CW-1:0]            step_cnt;
    logic [REFRESH_BITS-1:0]  refresh_cnt;
    logic [SW-1:0]            sel;
    logic                     step_tick;
    logic                     refresh_tick;

    logic [SW-1:0]            col;
    logic [PW:0]              idx_sum;
    logic [PW-1:0]            idx;
    logic [3:0]               nib;
    logic [6:0]               seg_dec;

    assign step_tick    = (step_cnt == STEP_LAST);
    assign refresh_tick = &refresh_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg      <= '0;
            pos      <= '0;
            state    <= BNC_FWD;
            step_cnt <= '0;
        end else if (load) begin
            msg      <= data;
            pos      <= '0;
            state    <= BNC_FWD;
            step_cnt <= '0;
        end else begin
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            if (step_tick && en) begin
                if (!mode) begin
                    if (!dir)
                        pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                    else
                        pos <= (pos == '0) ? POS_LAST : pos - 1'b1;
                end else if (state == BNC_FWD) begin
                    if (pos < PMAX) begin
                        pos <= pos + 1'b1;
                    end else begin
                        pos   <= PMAX - 1'b1;
                        state <= BNC_REV;
                    end
                end else begin
                    // pos can sit beyond PMAX after a switch out of wrap mode
                    if (pos == '0) begin
                        pos   <= PW'(1);
                        state <= BNC_FWD;
                    end else if (pos > PMAX) begin
                        pos <= PMAX - 1'b1;
                    end else begin
                        pos <= pos - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= SEL_FIRST;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (refresh_tick)
                sel <= (sel == '0) ? SEL_FIRST : sel - 1'b1;
        end
    end

    // pos + col < 2*MSG_LEN, so one conditional subtract gives the modulo.
    assign col     = SEL_FIRST - sel;
    assign idx_sum = {1'b0, pos} + (PW+1)'(col);
    assign idx     = (idx_sum >= MSG_LEN_X) ? idx_sum[PW-1:0] - MSG_LEN_T
                                            : idx_sum[PW-1:0];
    assign nib     = msg[idx];

    sseg_hex_decoder u_hex_decoder (
        .hex (nib),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= '1;
            sseg <= SEG_BLANK;
        end else begin
            an   <= ~(DIGITS'(1) << sel);
            sseg <= seg_dec;
        end
    end

endmodule
